// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - direct-mapped branch target buffer with 2-bit counters and mispredict redirect
// Optional macro BP_PERF_CNT_EN adds saturating branch/mispredict performance counters.
module branch_predict_unit #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] fetch_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic            ex_jump,
  input  logic            ex_branch,
  input  logic [XLEN-1:0] ex_alu_result,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic [XLEN-1:0] pc_plus_4,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     perf_branches,
  output logic [31:0]     perf_mispredicts
);

  localparam int IW = $clog2(ENTRIES);
  localparam int TW = XLEN - IW - 2;

  logic [ENTRIES-1:0] valid_q;
  logic [TW-1:0]      tag_q    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];

  logic [IW-1:0]   f_idx;
  logic [TW-1:0]   f_tag;
  logic            f_hit;
  logic [IW-1:0]   e_idx;
  logic [TW-1:0]   e_tag;
  logic            e_hit;
  logic            is_branch;
  logic            cond_taken;
  logic            actual_taken;
  logic [XLEN-1:0] actual_target;
  logic            mispredict;
  logic            update;

  assign f_idx       = fetch_pc[IW+1:2];
  assign f_tag       = fetch_pc[XLEN-1:IW+2];
  assign f_hit       = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign pred_taken  = f_hit && ctr_q[f_idx][1];
  assign pred_target = pred_taken ? target_q[f_idx] : fetch_pc + XLEN'(4);

  // A jump flag overrides the branch flag, so the target always comes from the ALU.
  assign is_branch     = ex_branch && !ex_jump;
  assign cond_taken    = is_branch && ex_alu_result[0];
  assign actual_taken  = ex_jump || cond_taken;
  assign actual_target = cond_taken ? ex_pc + ex_imm : ex_alu_result;
  assign pc_plus_4     = ex_pc + XLEN'(4);
  assign mispredict    = ex_valid && ((ex_pred_taken != actual_taken) ||
                         (actual_taken && (ex_pred_target != actual_target)));
  assign update        = ex_valid && (ex_branch || ex_jump);

  assign e_idx = ex_pc[IW+1:2];
  assign e_tag = ex_pc[XLEN-1:IW+2];
  assign e_hit = valid_q[e_idx] && (tag_q[e_idx] == e_tag);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'd1;
      end
    end else if (update) begin
      if (e_hit) begin
        if (actual_taken) begin
          target_q[e_idx] <= actual_target;
          if (ctr_q[e_idx] != 2'd3) ctr_q[e_idx] <= ctr_q[e_idx] + 2'd1;
        end else if (ctr_q[e_idx] != 2'd0) begin
          ctr_q[e_idx] <= ctr_q[e_idx] - 2'd1;
        end
      end else if (actual_taken) begin
        valid_q[e_idx]  <= 1'b1;
        tag_q[e_idx]    <= e_tag;
        target_q[e_idx] <= actual_target;
        ctr_q[e_idx]    <= ex_jump ? 2'd3 : 2'd2;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect    <= 1'b0;
      redirect_pc <= '0;
    end else begin
      redirect <= mispredict;
      if (mispredict) redirect_pc <= actual_taken ? actual_target : pc_plus_4;
    end
  end

`ifdef BP_PERF_CNT_EN
  logic [31:0] br_cnt_q;
  logic [31:0] mp_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else begin
      if (update && (br_cnt_q != 32'hFFFF_FFFF)) br_cnt_q <= br_cnt_q + 32'd1;
      if (mispredict && (mp_cnt_q != 32'hFFFF_FFFF)) mp_cnt_q <= mp_cnt_q + 32'd1;
    end
  end

  assign perf_branches    = br_cnt_q;
  assign perf_mispredicts = mp_cnt_q;
`else
  assign perf_branches    = 32'd0;
  assign perf_mispredicts = 32'd0;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// tb/tb_branch_predict_unit.sv - randomized self-checking bench for branch_predict_unit
// Reference model keeps the predictor table as plain arrays updated from the resolution rules.
module tb_branch_predict_unit;

  localparam int XLEN    = 32;
  localparam int ENTRIES = 16;
  localparam int IW      = 4;

  logic            clk;
  logic            rst_n;
  logic [XLEN-1:0] fetch_pc;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_imm;
  logic            ex_jump;
  logic            ex_branch;
  logic [XLEN-1:0] ex_alu_result;
  logic            ex_pred_taken;
  logic [XLEN-1:0] ex_pred_target;
  logic [XLEN-1:0] pc_plus_4;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic [31:0]     perf_branches;
  logic [31:0]     perf_mispredicts;

  branch_predict_unit #(.XLEN(XLEN), .ENTRIES(ENTRIES)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_pc(fetch_pc), .pred_taken(pred_taken),
    .pred_target(pred_target), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_jump(ex_jump), .ex_branch(ex_branch), .ex_alu_result(ex_alu_result),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target), .pc_plus_4(pc_plus_4),
    .redirect(redirect), .redirect_pc(redirect_pc), .perf_branches(perf_branches),
    .perf_mispredicts(perf_mispredicts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  bit          m_valid [ENTRIES];
  logic [31:0] m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  int unsigned m_br;
  int unsigned m_mp;

  logic [31:0] pool [6] = '{32'h100, 32'h104, 32'h140, 32'h200, 32'h1100, 32'h300};

  function automatic void model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0;
      m_ctr[i]   = 1;
    end
    m_br = 0;
    m_mp = 0;
  endfunction

  function automatic void model_lookup(input logic [31:0] pc, output bit t, output logic [31:0] tgt);
    int i = int'((pc >> 2) % ENTRIES);
    bit hit = m_valid[i] && (m_tag[i] == (pc >> (IW + 2)));
    t   = hit && (m_ctr[i] >= 2);
    tgt = t ? m_tgt[i] : pc + 32'd4;
  endfunction

  task automatic check_pred(input logic [31:0] pc, input string name);
    bit et;
    logic [31:0] etg;
    fetch_pc = pc;
    #1;
    model_lookup(pc, et, etg);
    tests++;
    if (pred_taken !== et || pred_target !== etg) begin
      fails++;
      $display("FAIL %s pc=%h got taken=%b target=%h want taken=%b target=%h",
               name, pc, pred_taken, pred_target, et, etg);
    end
  endtask

  task automatic check_perf(input string name);
    logic [31:0] eb = 0;
    logic [31:0] em = 0;
`ifdef BP_PERF_CNT_EN
    eb = m_br;
    em = m_mp;
`endif
    tests++;
    if (perf_branches !== eb || perf_mispredicts !== em) begin
      fails++;
      $display("FAIL %s_perf got br=%0d mp=%0d want br=%0d mp=%0d",
               name, perf_branches, perf_mispredicts, eb, em);
    end
  endtask

  // One resolution cycle: drive at negedge, check same-cycle lookup, then the registered redirect.
  task automatic resolve(input bit v, input logic [31:0] pc, input logic [31:0] imm, input bit j,
                         input bit b, input logic [31:0] alu, input bit pt, input logic [31:0] ptgt,
                         input string name);
    bit taken, mis, upd, ct;
    logic [31:0] tgt, rpc;
    int i;
    @(negedge clk);
    ex_valid = v; ex_pc = pc; ex_imm = imm; ex_jump = j; ex_branch = b;
    ex_alu_result = alu; ex_pred_taken = pt; ex_pred_target = ptgt;
    check_pred(pc, {name, "_lookup"});
    tests++;
    if (pc_plus_4 !== pc + 32'd4) begin
      fails++;
      $display("FAIL %s_pc4 got %h want %h", name, pc_plus_4, pc + 32'd4);
    end
    ct    = b && !j && alu[0];
    taken = j || ct;
    tgt   = ct ? pc + imm : alu;
    mis   = v && ((pt != taken) || (taken && ptgt != tgt));
    upd   = v && (b || j);
    rpc   = taken ? tgt : pc + 32'd4;
    @(posedge clk);
    #1;
    tests++;
    if (redirect !== mis || (mis && redirect_pc !== rpc)) begin
      fails++;
      $display("FAIL %s_redirect got %b pc=%h want %b pc=%h", name, redirect, redirect_pc, mis, rpc);
    end
    i = int'((pc >> 2) % ENTRIES);
    if (upd) begin
      m_br++;
      if (m_valid[i] && m_tag[i] == (pc >> (IW + 2))) begin
        if (taken) begin
          m_tgt[i] = tgt;
          m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
        end else begin
          m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
        end
      end else if (taken) begin
        m_valid[i] = 1;
        m_tag[i]   = pc >> (IW + 2);
        m_tgt[i]   = tgt;
        m_ctr[i]   = j ? 3 : 2;
      end
    end
    if (mis) m_mp++;
    ex_valid = 0;
    check_perf(name);
  endtask

  task automatic test_reset();
    rst_n = 0; ex_valid = 0; ex_pc = 0; ex_imm = 0; ex_jump = 0; ex_branch = 0;
    ex_alu_result = 0; ex_pred_taken = 0; ex_pred_target = 0; fetch_pc = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    fetch_pc = 32'h100;
    #1;
    tests++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
      fails++;
      $display("FAIL reset_lookup got taken=%b target=%h want 0 00000104", pred_taken, pred_target);
    end
    tests++;
    if (redirect !== 1'b0 || redirect_pc !== 32'h0) begin
      fails++;
      $display("FAIL reset_redirect got %b pc=%h want 0 0", redirect, redirect_pc);
    end
    check_perf("reset");
  endtask

  task automatic test_directed();
    resolve(1, 32'h100, 32'h20, 0, 1, 32'h1, 0, 32'h0, "beq_taken");
    check_pred(32'h100, "beq_alloc");
    tests++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h120) begin
      fails++;
      $display("FAIL beq_alloc_const got taken=%b target=%h want 1 00000120", pred_taken, pred_target);
    end
    resolve(1, 32'h100, 32'h20, 0, 1, 32'h0, 1, 32'h120, "beq_nt1");
    resolve(1, 32'h100, 32'h20, 0, 1, 32'h0, 0, 32'h104, "beq_nt2");
    check_pred(32'h100, "beq_weak");
    resolve(1, 32'h200, 32'h0, 1, 0, 32'h3000, 1, 32'h2FFC, "jalr_wrong_tgt");
    check_pred(32'h200, "jalr_alloc");
    resolve(1, 32'h200, 32'h0, 1, 0, 32'h3000, 1, 32'h3000, "jalr_correct");
    resolve(1, 32'h140, 32'h8, 1, 1, 32'h4000, 0, 32'h0, "jump_and_branch");
    check_pred(32'h100, "alias_evict");
  endtask

  task automatic test_back_to_back();
    resolve(1, 32'h300, 32'h40, 0, 1, 32'h1, 0, 32'h0, "b2b_a");
    resolve(1, 32'h1100, 32'h0, 1, 0, 32'h5000, 0, 32'h0, "b2b_b");
    resolve(0, 32'h300, 32'h40, 0, 1, 32'h1, 0, 32'h0, "b2b_idle");
  endtask

  task automatic test_random();
    bit pt;
    logic [31:0] ptgt, pc, alu;
    logic [31:0] tgts [4] = '{32'h3000, 32'h3004, 32'h8000, 32'h124};
    for (int n = 0; n < 400; n++) begin
      pc  = pool[$urandom_range(0, 5)];
      alu = ($urandom_range(0, 1) == 1) ? tgts[$urandom_range(0, 3)] : 32'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) model_lookup(pc, pt, ptgt);
      else begin
        pt   = 1'($urandom_range(0, 1));
        ptgt = tgts[$urandom_range(0, 3)];
      end
      resolve($urandom_range(0, 7) != 0, pc, 32'($urandom_range(0, 15)) << 2,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), alu, pt, ptgt, "rand");
      if (n % 8 == 0) begin
        @(negedge clk);
        check_pred(pool[$urandom_range(0, 5)], "rand_fetch");
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    ex_valid = 1; ex_pc = 32'h500; ex_imm = 32'h40; ex_jump = 1; ex_branch = 0;
    ex_alu_result = 32'h9000; ex_pred_taken = 0; ex_pred_target = 0;
    #2;
    rst_n = 0;
    #1;
    model_reset();
    tests++;
    if (redirect !== 1'b0 || redirect_pc !== 32'h0) begin
      fails++;
      $display("FAIL midreset_redirect got %b pc=%h want 0 0", redirect, redirect_pc);
    end
    check_perf("midreset");
    @(posedge clk);
    @(negedge clk);
    ex_valid = 0;
    rst_n = 1;
    @(posedge clk);
    #1;
    tests++;
    if (redirect !== 1'b0) begin
      fails++;
      $display("FAIL midreset_after got redirect=%b want 0", redirect);
    end
    @(negedge clk);
    for (int i = 0; i < 6; i++) check_pred(pool[i], "midreset_empty");
    resolve(1, 32'h100, 32'h20, 0, 1, 32'h1, 1, 32'h120, "post_reset");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 Parameter: XLEN, default 32, datapath/address width in bits.
REQ-002 Parameter: ENTRIES, default 16, predictor table depth; power of two, 4..256.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 fetch_pc  input  XLEN  PC being fetched this cycle.
REQ-006 pred_taken  output  1  prediction for fetch_pc: taken.
REQ-007 pred_target  output  XLEN  predicted next PC for fetch_pc.
REQ-008 ex_valid  input  1  qualifies all ex_* inputs; resolving instruction present.
REQ-009 ex_pc  input  XLEN  PC of the resolving instruction.
REQ-010 ex_imm  input  XLEN  branch offset.
REQ-011 ex_jump  input  1  instruction is JAL/JALR.
REQ-012 ex_branch  input  1  instruction is a conditional branch.
REQ-013 ex_alu_result  input  XLEN  bit 0 is the branch condition; full value is the jump target.
REQ-014 ex_pred_taken  input  1  prediction carried down the pipe for ex_pc.
REQ-015 ex_pred_target  input  XLEN  predicted target carried down the pipe for ex_pc.
REQ-016 pc_plus_4  output  XLEN  ex_pc + 4, combinational.
REQ-017 redirect  output  1  registered mispredict flush; single-cycle pulse.
REQ-018 redirect_pc  output  XLEN  registered correct next PC; valid while redirect=1.
REQ-019 perf_branches  output  32  count of resolved branches/jumps.
REQ-020 perf_mispredicts  output  32  count of mispredicts.

Function
REQ-021 Indexing: idx = pc[log2(ENTRIES)+1:2]; tag = pc[XLEN-1:log2(ENTRIES)+2].
REQ-022 Entry fields: valid, tag, target (XLEN), 2-bit saturating counter.
REQ-023 Lookup is combinational, zero latency: hit = valid and tag match.
REQ-024 Lookup outputs: pred_taken = hit and counter[1]; pred_target = target if pred_taken, else fetch_pc+4 (modulo 2^XLEN).
REQ-025 Resolution: cond_taken = ex_branch and ex_alu_result[0].
REQ-026 Resolution: actual_taken = ex_jump or cond_taken.
REQ-027 Resolution: actual_target = ex_pc+ex_imm if cond_taken, else ex_alu_result.
REQ-028 Mispredict = ex_valid and (ex_pred_taken != actual_taken, or actual_taken and ex_pred_target != actual_target).
REQ-029 Next edge after a mispredict: redirect=1 and redirect_pc = actual_target if actual_taken, else pc_plus_4.
REQ-030 redirect deasserts the following cycle unless a new mispredict is resolved; back-to-back mispredicts give back-to-back pulses.
REQ-031 Update fires when ex_valid and (ex_branch or ex_jump).
REQ-032 Update on hit: counter +1 if actual_taken, -1 otherwise, saturating at 3 and 0; target written when actual_taken.
REQ-033 Update on miss, taken: allocate the entry (overwrite, no replacement policy); counter = 3 for a jump, 2 for a branch.
REQ-034 Update on miss, not-taken: no allocation.
REQ-035 Lookup and update to the same idx in one cycle: lookup returns pre-update contents (no bypass).
REQ-036 ex_branch and ex_jump both 1: treated as a jump.
REQ-037 ex_valid=0: no update, no redirect, no count.

Reset
REQ-038 rst_n low asynchronously clears all valid bits, sets all counters to 1, and clears redirect, redirect_pc and both perf counters.
REQ-039 A resolution in flight when reset asserts is discarded; no redirect after release.

Configuration
REQ-040 Macro BP_PERF_CNT_EN defined: perf_branches increments per update event (REQ-031); perf_mispredicts increments per mispredict; both saturate at 32'hFFFF_FFFF.
REQ-041 Macro BP_PERF_CNT_EN undefined: both perf outputs tied to 0 and no counter flops are instantiated.

Verification
REQ-042 Reset, then fetch_pc=0x100 -> pred_taken=0, pred_target=0x104.
REQ-043 BEQ at ex_pc=0x100, ex_imm=0x20, alu[0]=1, ex_pred_taken=0 -> next cycle redirect=1, redirect_pc=0x120; afterwards fetch 0x100 -> pred_taken=1, pred_target=0x120.
REQ-044 Same branch resolved not-taken twice from counter 2 -> counter 0; fetch 0x100 -> pred_taken=0; redirect_pc=0x104 on the first not-taken.
REQ-045 JALR at 0x200, alu_result=0x3000, ex_pred_taken=1, ex_pred_target=0x2FFC -> redirect=1, redirect_pc=0x3000, target entry updated.
REQ-046 Correct prediction (pred_taken=1, target matches) -> redirect stays 0, perf_branches+1, perf_mispredicts unchanged (BP_PERF_CNT_EN defined); rst_n pulsed mid-sequence -> all counts 0, table empty.
